// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with wrap or saturate at the modulus boundaries,
// a one-cycle terminal-count strobe and a sticky boundary flag.
module param_updown_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd0,
  parameter longint unsigned STEP     = 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up_down,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] qd,
  output logic [WIDTH-1:0] qd_b,
  output logic             tc,
  output logic             bnd_flag
);

  localparam longint unsigned MOD = (MODULUS == 64'd0) ? (64'd1 << WIDTH) : MODULUS;

  // MOD_W is MOD reduced to WIDTH bits (0 for a full power-of-two range);
  // the wrap sums below are exact modulo 2^WIDTH, so that truncation is harmless.
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MOD - 64'd1);
  localparam logic [WIDTH-1:0] MOD_W  = WIDTH'(MOD);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH:0]   MAX_X  = {1'b0, MAX_W};

  if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be in 2..32");
  end
  if ((MODULUS != 64'd0) && ((MODULUS < 64'd2) || (MODULUS > (64'd1 << WIDTH)))) begin : g_bad_mod
    $error("param_updown_counter: MODULUS must be 0 or in 2..2^WIDTH");
  end
  if ((STEP < 64'd1) || (STEP > (MOD - 64'd1))) begin : g_bad_step
    $error("param_updown_counter: STEP must be in 1..MAX");
  end

  logic [WIDTH-1:0] qd_q, qd_d;
  logic [WIDTH-1:0] qd_b_q, qd_b_d;
  logic             tc_q, tc_d;
  logic             bnd_flag_q, bnd_flag_d;

  logic [WIDTH:0]   up_sum_s;
  logic [WIDTH-1:0] up_wrap_s;
  logic [WIDTH-1:0] dn_diff_s;
  logic [WIDTH-1:0] dn_wrap_s;
  logic             up_over_s;
  logic             dn_under_s;
  logic             bnd_event_s;

  // up_sum_s carries one extra bit so the overflow test sees the true sum.
  assign up_sum_s   = {1'b0, qd_q} + {1'b0, STEP_W};
  assign up_wrap_s  = qd_q + STEP_W - MOD_W;
  assign dn_diff_s  = qd_q - STEP_W;
  assign dn_wrap_s  = qd_q + MOD_W - STEP_W;
  assign up_over_s  = (up_sum_s > MAX_X);
  assign dn_under_s = (qd_q < STEP_W);

  always_comb begin
    qd_d        = qd_q;
    bnd_event_s = 1'b0;
    if (load) begin
      if (d > MAX_W) begin
        qd_d = MAX_W;
      end else begin
        qd_d = d;
      end
    end else if (en) begin
      if (up_down) begin
        if (up_over_s) begin
          bnd_event_s = 1'b1;
          qd_d        = SATURATE ? MAX_W : up_wrap_s;
        end else begin
          qd_d = up_sum_s[WIDTH-1:0];
        end
      end else begin
        if (dn_under_s) begin
          bnd_event_s = 1'b1;
          qd_d        = SATURATE ? {WIDTH{1'b0}} : dn_wrap_s;
        end else begin
          qd_d = dn_diff_s;
        end
      end
    end else begin
      qd_d = qd_q;
    end
    qd_b_d     = ~qd_d;
    tc_d       = bnd_event_s;
    // A boundary event in the same cycle as clr_flag keeps the flag set.
    bnd_flag_d = bnd_event_s | (bnd_flag_q & ~clr_flag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qd_q       <= {WIDTH{1'b0}};
      qd_b_q     <= {WIDTH{1'b1}};
      tc_q       <= 1'b0;
      bnd_flag_q <= 1'b0;
    end else begin
      qd_q       <= qd_d;
      qd_b_q     <= qd_b_d;
      tc_q       <= tc_d;
      bnd_flag_q <= bnd_flag_d;
    end
  end

  assign qd       = qd_q;
  assign qd_b     = qd_b_q;
  assign tc       = tc_q;
  assign bnd_flag = bnd_flag_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: five counter configurations share one set of control
// inputs; directed scenarios plus randomized traffic against an arithmetic model.
module tb_param_updown_counter;

  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, load, up_down, clr_flag;
  logic [7:0] d0, q0, qb0;
  logic [3:0] d1, q1, qb1;
  logic [3:0] d2, q2, qb2;
  logic [5:0] d3, q3, qb3;
  logic [4:0] d4, q4, qb4;
  logic tc0, tc1, tc2, tc3, tc4;
  logic bf0, bf1, bf2, bf3, bf4;

  int tests_run = 0;
  int tests_failed = 0;

  longint wid_a[NI]  = '{8, 4, 4, 6, 5};
  longint mod_a[NI]  = '{256, 10, 16, 50, 21};
  longint step_a[NI] = '{1, 3, 4, 7, 4};
  bit     sat_a[NI]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  longint m_q[NI];
  bit     m_tc[NI];
  bit     m_bf[NI];

  param_updown_counter #(.WIDTH(8), .MODULUS(64'd0), .STEP(64'd1), .SATURATE(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .up_down(up_down), .d(d0),
    .clr_flag(clr_flag), .qd(q0), .qd_b(qb0), .tc(tc0), .bnd_flag(bf0));
  param_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .STEP(64'd3), .SATURATE(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .up_down(up_down), .d(d1),
    .clr_flag(clr_flag), .qd(q1), .qd_b(qb1), .tc(tc1), .bnd_flag(bf1));
  param_updown_counter #(.WIDTH(4), .MODULUS(64'd0), .STEP(64'd4), .SATURATE(1'b1)) u2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .up_down(up_down), .d(d2),
    .clr_flag(clr_flag), .qd(q2), .qd_b(qb2), .tc(tc2), .bnd_flag(bf2));
  param_updown_counter #(.WIDTH(6), .MODULUS(64'd50), .STEP(64'd7), .SATURATE(1'b0)) u3 (
    .clk(clk), .rst(rst), .en(en), .load(load), .up_down(up_down), .d(d3),
    .clr_flag(clr_flag), .qd(q3), .qd_b(qb3), .tc(tc3), .bnd_flag(bf3));
  param_updown_counter #(.WIDTH(5), .MODULUS(64'd21), .STEP(64'd4), .SATURATE(1'b1)) u4 (
    .clk(clk), .rst(rst), .en(en), .load(load), .up_down(up_down), .d(d4),
    .clr_flag(clr_flag), .qd(q4), .qd_b(qb4), .tc(tc4), .bnd_flag(bf4));

  function automatic longint d_of(int i);
    case (i)
      0: return longint'(d0);
      1: return longint'(d1);
      2: return longint'(d2);
      3: return longint'(d3);
      default: return longint'(d4);
    endcase
  endfunction

  function automatic logic [63:0] q_of(int i);
    case (i)
      0: return 64'(q0);
      1: return 64'(q1);
      2: return 64'(q2);
      3: return 64'(q3);
      default: return 64'(q4);
    endcase
  endfunction

  function automatic logic [63:0] qb_of(int i);
    case (i)
      0: return 64'(qb0);
      1: return 64'(qb1);
      2: return 64'(qb2);
      3: return 64'(qb3);
      default: return 64'(qb4);
    endcase
  endfunction

  function automatic logic tc_of(int i);
    case (i)
      0: return tc0;
      1: return tc1;
      2: return tc2;
      3: return tc3;
      default: return tc4;
    endcase
  endfunction

  function automatic logic bf_of(int i);
    case (i)
      0: return bf0;
      1: return bf1;
      2: return bf2;
      3: return bf3;
      default: return bf4;
    endcase
  endfunction

  // Reference: the counting rules applied with plain integer arithmetic.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      longint mx = mod_a[i] - 1;
      longint q = m_q[i];
      longint nq = q;
      bit ev = 1'b0;
      if (rst) begin
        m_q[i] = 0; m_tc[i] = 1'b0; m_bf[i] = 1'b0;
      end else begin
        if (load) begin
          nq = (d_of(i) > mx) ? mx : d_of(i);
        end else if (en) begin
          if (up_down) begin
            if (q + step_a[i] <= mx) nq = q + step_a[i];
            else begin ev = 1'b1; nq = sat_a[i] ? mx : q + step_a[i] - mod_a[i]; end
          end else begin
            if (q >= step_a[i]) nq = q - step_a[i];
            else begin ev = 1'b1; nq = sat_a[i] ? 0 : q + mod_a[i] - step_a[i]; end
          end
        end
        m_q[i]  = nq;
        m_tc[i] = ev;
        m_bf[i] = ev | (m_bf[i] & !clr_flag);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; en = 1'b0; load = 1'b0; up_down = 1'b1; clr_flag = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b0; up_down = 1'b1; clr_flag = 1'b0;
    d0 = 8'h00; d1 = 4'h0; d2 = 4'h0; d3 = 6'h00; d4 = 5'h00;
    tick(); tick();
    tests_run++; if (q0 !== 8'h00) begin tests_failed++; $display("FAIL reset_qd got %h want 00", q0); end
    tests_run++; if (qb0 !== 8'hFF) begin tests_failed++; $display("FAIL reset_qd_b got %h want ff", qb0); end
    tests_run++; if (tc0 !== 1'b0) begin tests_failed++; $display("FAIL reset_tc got %b want 0", tc0); end
    tests_run++; if (bf0 !== 1'b0) begin tests_failed++; $display("FAIL reset_flag got %b want 0", bf0); end
    tests_run++; if (qb3 !== 6'h3F) begin tests_failed++; $display("FAIL reset_qd_b_w6 got %h want 3f", qb3); end
    rst = 1'b0; en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++; if (q0 !== 8'h00) begin tests_failed++; $display("FAIL hold_idle cyc %0d got %h want 00", k, q0); end
    end
  endtask

  task automatic test_wrap_up();
    logic [7:0] exp_q[3] = '{8'hFF, 8'h00, 8'h01};
    logic       exp_tc[3] = '{1'b0, 1'b1, 1'b0};
    idle_inputs(); load = 1'b1; d0 = 8'hFE;
    tick();
    load = 1'b0; en = 1'b1; up_down = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++; if (q0 !== exp_q[k]) begin tests_failed++; $display("FAIL wrap_up_q cyc %0d got %h want %h", k, q0, exp_q[k]); end
      tests_run++; if (tc0 !== exp_tc[k]) begin tests_failed++; $display("FAIL wrap_up_tc cyc %0d got %b want %b", k, tc0, exp_tc[k]); end
    end
    tests_run++; if (bf0 !== 1'b1) begin tests_failed++; $display("FAIL wrap_up_flag got %b want 1", bf0); end
    en = 1'b0;
  endtask

  task automatic test_mod_step();
    idle_inputs(); load = 1'b1; d1 = 4'd2;
    tick();
    load = 1'b0; en = 1'b1; up_down = 1'b0;
    tick();
    tests_run++; if (q1 !== 4'd9) begin tests_failed++; $display("FAIL mod_down_q got %0d want 9", q1); end
    tests_run++; if (tc1 !== 1'b1) begin tests_failed++; $display("FAIL mod_down_tc got %b want 1", tc1); end
    en = 1'b0; load = 1'b1; d1 = 4'd15;
    tick();
    tests_run++; if (q1 !== 4'd9) begin tests_failed++; $display("FAIL mod_clamp_q got %0d want 9", q1); end
    tests_run++; if (tc1 !== 1'b0) begin tests_failed++; $display("FAIL mod_clamp_tc got %b want 0", tc1); end
    load = 1'b0;
  endtask

  task automatic test_saturate();
    idle_inputs(); load = 1'b1; d2 = 4'd13;
    tick();
    load = 1'b0; en = 1'b1; up_down = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++; if (q2 !== 4'd15) begin tests_failed++; $display("FAIL sat_up_q cyc %0d got %0d want 15", k, q2); end
      tests_run++; if (tc2 !== 1'b1) begin tests_failed++; $display("FAIL sat_up_tc cyc %0d got %b want 1", k, tc2); end
    end
    en = 1'b0; load = 1'b1; d2 = 4'd2;
    tick();
    load = 1'b0; en = 1'b1; up_down = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++; if (q2 !== 4'd0) begin tests_failed++; $display("FAIL sat_dn_q cyc %0d got %0d want 0", k, q2); end
      tests_run++; if (tc2 !== 1'b1) begin tests_failed++; $display("FAIL sat_dn_tc cyc %0d got %b want 1", k, tc2); end
    end
    en = 1'b0;
  endtask

  task automatic test_priority();
    idle_inputs(); load = 1'b1; en = 1'b1; d0 = 8'h55;
    tick();
    tests_run++; if (q0 !== 8'h55) begin tests_failed++; $display("FAIL load_over_en_q got %h want 55", q0); end
    tests_run++; if (tc0 !== 1'b0) begin tests_failed++; $display("FAIL load_over_en_tc got %b want 0", tc0); end
    rst = 1'b1;
    tick();
    tests_run++; if (q0 !== 8'h00) begin tests_failed++; $display("FAIL rst_over_load_q got %h want 00", q0); end
    rst = 1'b0; d0 = 8'hFF;
    tick();
    load = 1'b0; en = 1'b1; up_down = 1'b1; clr_flag = 1'b1;
    tick();
    tests_run++; if (q0 !== 8'h00) begin tests_failed++; $display("FAIL clr_wrap_q got %h want 00", q0); end
    tests_run++; if (bf0 !== 1'b1) begin tests_failed++; $display("FAIL clr_vs_set_flag got %b want 1", bf0); end
    en = 1'b0;
    tick();
    tests_run++; if (bf0 !== 1'b0) begin tests_failed++; $display("FAIL clr_flag got %b want 0", bf0); end
    tests_run++; if (tc0 !== 1'b0) begin tests_failed++; $display("FAIL clr_tc got %b want 0", tc0); end
    clr_flag = 1'b0;
  endtask

  task automatic test_direction();
    idle_inputs(); rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; up_down = 1'b1;
    tick(); tick(); tick();
    tests_run++; if (q0 !== 8'd3) begin tests_failed++; $display("FAIL dir_up_q got %0d want 3", q0); end
    up_down = 1'b0;
    tick();
    tests_run++; if (q0 !== 8'd2) begin tests_failed++; $display("FAIL dir_down_q got %0d want 2", q0); end
    rst = 1'b1;
    tick();
    tests_run++; if (q0 !== 8'd0) begin tests_failed++; $display("FAIL mid_rst_q got %0d want 0", q0); end
    rst = 1'b0; up_down = 1'b1;
    tick();
    tests_run++; if (q0 !== 8'd1) begin tests_failed++; $display("FAIL resume_q got %0d want 1", q0); end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_down  = $urandom_range(0, 1);
      clr_flag = ($urandom_range(0, 9) == 0);
      d0 = 8'($urandom); d1 = 4'($urandom); d2 = 4'($urandom);
      d3 = 6'($urandom); d4 = 5'($urandom);
      tick();
      for (int i = 0; i < NI; i++) begin
        logic [63:0] eq  = 64'(m_q[i]);
        logic [63:0] eqb = 64'((~m_q[i]) & ((64'sd1 <<< wid_a[i]) - 1));
        tests_run++; if (q_of(i) !== eq) begin tests_failed++; $display("FAIL rand_q inst %0d cyc %0d got %0d want %0d", i, k, q_of(i), eq); end
        tests_run++; if (qb_of(i) !== eqb) begin tests_failed++; $display("FAIL rand_qd_b inst %0d cyc %0d got %0h want %0h", i, k, qb_of(i), eqb); end
        tests_run++; if (tc_of(i) !== m_tc[i]) begin tests_failed++; $display("FAIL rand_tc inst %0d cyc %0d got %b want %b", i, k, tc_of(i), m_tc[i]); end
        tests_run++; if (bf_of(i) !== m_bf[i]) begin tests_failed++; $display("FAIL rand_flag inst %0d cyc %0d got %b want %b", i, k, bf_of(i), m_bf[i]); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_q[i] = 0; m_tc[i] = 1'b0; m_bf[i] = 1'b0;
    end
    #1;
    test_reset();
    test_wrap_up();
    test_mod_step();
    test_saturate();
    test_priority();
    test_direction();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
